// File: rtl/cycle_seq_pkg.sv
// Shared types and defaults for the cycle sequencer.
// Optional watchdog build: CYCLE_SEQ_WATCHDOG_EN.
package cycle_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ERROR
  } state_t;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_NUM_PHASES = 4;
  localparam int DEF_TIMEOUT    = 255;
  localparam int WD_CNT_W       = 16;

  function automatic int phase_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-cycle counter for the sequencer; expired flags TIMEOUT cycles in WAIT.
// Instantiated only when CYCLE_SEQ_WATCHDOG_EN is defined.
module seq_watchdog
  import cycle_seq_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam logic [WD_CNT_W-1:0] LAST = WD_CNT_W'(TIMEOUT - 1);

  logic [WD_CNT_W-1:0] cnt;

  assign expired = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (kick) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + WD_CNT_W'(1);
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Start/done sequencer with phase and completed-operation counters.
// Define CYCLE_SEQ_WATCHDOG_EN to build the WAIT timeout and ERROR state.
module cycle_sequencer
  import cycle_seq_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           clear,
  input  logic                           done,
  output logic                           start,
  output logic                           busy,
  output logic [phase_w(NUM_PHASES)-1:0] phase,
  output logic [CNT_W-1:0]               count,
  output logic                           wrap,
  output logic                           timeout_err
);

  localparam int PW = phase_w(NUM_PHASES);
  localparam logic [PW-1:0] PH_LAST = PW'(NUM_PHASES - 1);

  if (NUM_PHASES < 2) begin : g_bad_phases
    $error("NUM_PHASES must be at least 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..65535");
  end

  state_t state;
  logic [PW-1:0] phase_nxt;
  logic wd_expired;

  assign phase_nxt = (phase == PH_LAST) ? '0 : phase + PW'(1);

`ifdef CYCLE_SEQ_WATCHDOG_EN
  logic wd_run;
  logic wd_kick;

  assign wd_run  = (state == WAIT);
  assign wd_kick = (state == ISSUE);

  seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (wd_run),
    .kick   (wd_kick),
    .expired(wd_expired)
  );
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      start <= 1'b0;
      busy  <= 1'b0;
      phase <= '0;
      count <= '0;
      wrap  <= 1'b0;
`ifdef CYCLE_SEQ_WATCHDOG_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
      wrap  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= ISSUE;
            start <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done) begin
            count <= count + CNT_W'(1);
            phase <= phase_nxt;
            wrap  <= &count;
            if (enable) begin
              state <= ISSUE;
              start <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (wd_expired) begin
            state <= ERROR;
            busy  <= 1'b0;
`ifdef CYCLE_SEQ_WATCHDOG_EN
            timeout_err <= 1'b1;
`endif
          end
        end
        ERROR: begin
          if (clear) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      // clear outranks the increment but never touches the state
      if (clear) begin
        count <= '0;
        phase <= '0;
        wrap  <= 1'b0;
`ifdef CYCLE_SEQ_WATCHDOG_EN
        timeout_err <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer (CNT_W=4, NUM_PHASES=4, TIMEOUT=8).
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       done = 1'b0;
  logic       start;
  logic       busy;
  logic [1:0] phase;
  logic [3:0] count;
  logic       wrap;
  logic       timeout_err;

  int vecs = 0;
  int errs = 0;

  cycle_sequencer #(
    .CNT_W     (4),
    .NUM_PHASES(4),
    .TIMEOUT   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .clear      (clear),
    .done       (done),
    .start      (start),
    .busy       (busy),
    .phase      (phase),
    .count      (count),
    .wrap       (wrap),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timed out");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    enable = 1'b1;
    step();
    step();
    vecs++;
    if ({start, busy, phase, count, wrap, timeout_err} !== 10'd0) begin
      errs++;
      $display("FAIL reset_outs: got %b want 0", {start, busy, phase, count, wrap, timeout_err});
    end
    enable = 1'b0;
    #3 rst_n = 1'b1;
    step();
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle_busy: got %0d want 0", busy);
    end
  endtask

  task automatic test_ops();
    bit found;
    do_clear();
    enable = 1'b1;
    for (int op = 0; op < 5; op++) begin
      found = 1'b0;
      for (int t = 0; t < 10 && !found; t++) begin
        if (start) found = 1'b1;
        else step();
      end
      vecs++;
      if (!found) begin
        errs++;
        $display("FAIL ops_start_seen op%0d: got 0 want 1", op);
      end
      step();
      vecs++;
      if (start !== 1'b0) begin
        errs++;
        $display("FAIL ops_start_width op%0d: got %0d want 0", op, start);
      end
      step();
      step();
      done = 1'b1;
      if (op == 4) enable = 1'b0;
      step();
      done = 1'b0;
      vecs++;
      if (count !== 4'(op + 1)) begin
        errs++;
        $display("FAIL ops_count op%0d: got %0d want %0d", op, count, op + 1);
      end
    end
    step();
    vecs++;
    if ({count, phase, busy, start} !== {4'd5, 2'd1, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL ops_final: got cnt=%0d ph=%0d busy=%0d start=%0d want 5 1 0 0", count, phase, busy, start);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    enable = 1'b1;
    done = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      vecs++;
      if (start !== 1'(i % 2) || count !== 4'((i - 1) / 2)) begin
        errs++;
        $display("FAIL b2b edge%0d: got start=%0d cnt=%0d want %0d %0d", i, start, count, i % 2, (i - 1) / 2);
      end
    end
    enable = 1'b0;
    step();
    done = 1'b0;
    vecs++;
    if ({count, phase, busy} !== {4'd5, 2'd1, 1'b0}) begin
      errs++;
      $display("FAIL b2b_final: got cnt=%0d ph=%0d busy=%0d want 5 1 0", count, phase, busy);
    end
  endtask

  task automatic test_wrap();
    int wraps;
    wraps = 0;
    do_clear();
    done = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      enable = (i < 33);
      step();
      if (wrap) wraps++;
      vecs++;
      if (wrap !== (i == 33) || count !== 4'(((i - 1) / 2) % 16)) begin
        errs++;
        $display("FAIL wrap edge%0d: got wrap=%0d cnt=%0d want %0d %0d", i, wrap, count, i == 33, ((i - 1) / 2) % 16);
      end
    end
    done = 1'b0;
    vecs++;
    if (wraps != 1 || phase !== 2'd0 || start !== 1'b0) begin
      errs++;
      $display("FAIL wrap_final: got wraps=%0d ph=%0d start=%0d want 1 0 0", wraps, phase, start);
    end
  endtask

  task automatic test_enable_drop();
    int starts;
    do_clear();
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL clear_in_wait_busy: got %0d want 1", busy);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    vecs++;
    if ({count, busy} !== {4'd1, 1'b0}) begin
      errs++;
      $display("FAIL drop_complete: got cnt=%0d busy=%0d want 1 0", count, busy);
    end
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (start) starts++;
    end
    vecs++;
    if (starts != 0) begin
      errs++;
      $display("FAIL drop_no_start: got %0d want 0", starts);
    end
    enable = 1'b1;
    step();
    step();
    done = 1'b1;
    clear = 1'b1;
    step();
    done = 1'b0;
    clear = 1'b0;
    vecs++;
    if ({count, phase, start, wrap} !== {4'd0, 2'd0, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL clear_done: got cnt=%0d ph=%0d start=%0d wrap=%0d want 0 0 1 0", count, phase, start, wrap);
    end
    enable = 1'b0;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    vecs++;
    if ({count, busy} !== {4'd1, 1'b0}) begin
      errs++;
      $display("FAIL clear_done_next: got cnt=%0d busy=%0d want 1 0", count, busy);
    end
  endtask

  task automatic test_watchdog();
    do_clear();
    enable = 1'b1;
    step();
    enable = 1'b0;
    step();
`ifdef CYCLE_SEQ_WATCHDOG_EN
    for (int i = 0; i < 7; i++) step();
    vecs++;
    if ({busy, timeout_err} !== 2'b10) begin
      errs++;
      $display("FAIL wd_before: got busy=%0d err=%0d want 1 0", busy, timeout_err);
    end
    step();
    vecs++;
    if ({busy, timeout_err, start} !== 3'b010) begin
      errs++;
      $display("FAIL wd_expire: got busy=%0d err=%0d start=%0d want 0 1 0", busy, timeout_err, start);
    end
    enable = 1'b1;
    done = 1'b1;
    for (int i = 0; i < 4; i++) step();
    done = 1'b0;
    vecs++;
    if ({count, phase, timeout_err, busy, start} !== {4'd0, 2'd0, 3'b100}) begin
      errs++;
      $display("FAIL wd_frozen: got cnt=%0d ph=%0d err=%0d busy=%0d start=%0d want 0 0 1 0 0", count, phase, timeout_err, busy, start);
    end
    enable = 1'b0;
    do_clear();
    vecs++;
    if ({timeout_err, busy} !== 2'b00) begin
      errs++;
      $display("FAIL wd_clear: got err=%0d busy=%0d want 0 0", timeout_err, busy);
    end
    enable = 1'b1;
    step();
    enable = 1'b0;
    vecs++;
    if ({start, busy} !== 2'b11) begin
      errs++;
      $display("FAIL wd_idle_restart: got start=%0d busy=%0d want 1 1", start, busy);
    end
    step();
    for (int i = 0; i < 7; i++) step();
    done = 1'b1;
    step();
    done = 1'b0;
    vecs++;
    if ({count, timeout_err, busy} !== {4'd1, 2'b00}) begin
      errs++;
      $display("FAIL wd_done_last: got cnt=%0d err=%0d busy=%0d want 1 0 0", count, timeout_err, busy);
    end
`else
    for (int i = 0; i < 1000; i++) step();
    vecs++;
    if ({busy, timeout_err} !== 2'b10) begin
      errs++;
      $display("FAIL nowd_wait: got busy=%0d err=%0d want 1 0", busy, timeout_err);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    vecs++;
    if ({count, busy, timeout_err} !== {4'd1, 2'b00}) begin
      errs++;
      $display("FAIL nowd_done: got cnt=%0d busy=%0d err=%0d want 1 0 0", count, busy, timeout_err);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_clear();
    enable = 1'b1;
    done = 1'b1;
    for (int i = 1; i <= 8; i++) step();
    done = 1'b0;
    vecs++;
    if ({count, busy} !== {4'd3, 1'b1}) begin
      errs++;
      $display("FAIL areset_setup: got cnt=%0d busy=%0d want 3 1", count, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({start, busy, phase, count, wrap, timeout_err} !== 10'd0) begin
      errs++;
      $display("FAIL areset_now: got %b want 0", {start, busy, phase, count, wrap, timeout_err});
    end
    enable = 1'b0;
    #1 rst_n = 1'b1;
    step();
    vecs++;
    if ({busy, count} !== 5'd0) begin
      errs++;
      $display("FAIL areset_after: got busy=%0d cnt=%0d want 0 0", busy, count);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_wrap();
    test_enable_drop();
    test_watchdog();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
